// File: rtl/mem_controller.sv
// Round-robin arbiter that relays NUM_CONSUMERS read/write requesters onto one
// memory read port and one memory write port, with one transaction in flight.
module mem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int unsigned PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                   state;
    logic [PTR_BITS-1:0]      rr_ptr;
    logic [PTR_BITS-1:0]      current;

    logic [NUM_CONSUMERS-1:0] pending;
    logic                     found;
    logic [PTR_BITS-1:0]      cand;
    logic [PTR_BITS-1:0]      pick;
    logic [PTR_BITS-1:0]      pick_next;
    logic [ADDR_BITS-1:0]     pick_read_address;
    logic [ADDR_BITS-1:0]     pick_write_address;
    logic [DATA_BITS-1:0]     pick_write_data;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        pending = (consumer_read_valid | consumer_write_valid)
                  & ~(consumer_read_ready | consumer_write_ready);
        found = 1'b0;
        cand  = '0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            cand = PTR_BITS'((32'(rr_ptr) + k) % NUM_CONSUMERS);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_next = (32'(pick) == NUM_CONSUMERS - 1) ? '0 : pick + PTR_BITS'(1);

        pick_read_address  = '0;
        pick_write_address = '0;
        pick_write_data    = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            if (pick == PTR_BITS'(k)) begin
                pick_read_address  = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
                pick_write_address = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
                pick_write_data    = consumer_write_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            current              <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A stalled issue leaves rr_ptr alone so the same requester wins next time.
                    if (found) begin
                        if (consumer_read_valid[pick]) begin
                            if (!mem_read_ready) begin
                                current          <= pick;
                                rr_ptr           <= pick_next;
                                mem_read_valid   <= 1'b1;
                                mem_read_address <= pick_read_address;
                                state            <= READ_WAITING;
                            end
                        end else if (!mem_write_ready) begin
                            current           <= pick;
                            rr_ptr            <= pick_next;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= pick_write_address;
                            mem_write_data    <= pick_write_data;
                            state             <= WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                            if (current == PTR_BITS'(k)) begin
                                consumer_read_data[k*DATA_BITS +: DATA_BITS] <= mem_read_data;
                            end
                        end
                        consumer_read_ready[current] <= 1'b1;
                        state                        <= READ_RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        mem_write_valid               <= 1'b0;
                        consumer_write_ready[current] <= 1'b1;
                        state                         <= WRITE_RELAYING;
                    end
                end
                READ_RELAYING: begin
                    if (!consumer_read_valid[current]) begin
                        consumer_read_ready[current] <= 1'b0;
                        state                        <= IDLE;
                    end
                end
                WRITE_RELAYING: begin
                    if (!consumer_write_valid[current]) begin
                        consumer_write_ready[current] <= 1'b0;
                        state                         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: memory responder, consumer agents and a round-robin
// reference model that predicts grant order and read data for each batch.
module tb_mem_controller;

    localparam int N = 4;
    localparam int A = 8;
    localparam int D = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   consumer_read_valid;
    logic [N*A-1:0] consumer_read_address;
    logic [N-1:0]   consumer_read_ready;
    logic [N*D-1:0] consumer_read_data;
    logic [N-1:0]   consumer_write_valid;
    logic [N*A-1:0] consumer_write_address;
    logic [N*D-1:0] consumer_write_data;
    logic [N-1:0]   consumer_write_ready;
    logic           mem_read_valid;
    logic [A-1:0]   mem_read_address;
    logic           mem_read_ready;
    logic [D-1:0]   mem_read_data;
    logic           mem_write_valid;
    logic [A-1:0]   mem_write_address;
    logic [D-1:0]   mem_write_data;
    logic           mem_write_ready;

    mem_controller #(
        .ADDR_BITS    (A),
        .DATA_BITS    (D),
        .NUM_CONSUMERS(N)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .consumer_write_valid  (consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data   (consumer_write_data),
        .consumer_write_ready  (consumer_write_ready),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data),
        .mem_write_valid       (mem_write_valid),
        .mem_write_address     (mem_write_address),
        .mem_write_data        (mem_write_data),
        .mem_write_ready       (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] mem[256];
    logic [D-1:0] ref_mem[256];
    int           model_rr;

    int           rd_lat, wr_lat, rd_cnt, wr_cnt;
    bit           rand_lat;

    int           req_rd[N], req_wr[N], rd_rem[N], wr_rem[N];
    logic [A-1:0] raddr[N], waddr[N];
    logic [D-1:0] wdata[N];
    logic [N-1:0] hold_rd;

    logic [N-1:0] prev_crr, prev_cwr;
    logic         prev_mrv, prev_mwv;
    int           log_who[$], log_kind[$];
    logic [D-1:0] log_data[$];
    int           exp_who[$], exp_kind[$];
    logic [D-1:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer wins, pointer moves past it.
    function automatic int predict_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (model_rr + k) % N;
            if (mask[c]) begin
                model_rr = (c + 1) % N;
                return c;
            end
        end
        return -1;
    endfunction

    // One clock: log completions, check memory-side protocol, run memory and consumers.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (consumer_read_ready[i] === 1'b1 && prev_crr[i] !== 1'b1) begin
                log_who.push_back(i);
                log_kind.push_back(0);
                log_data.push_back(consumer_read_data[i*D +: D]);
            end
            if (consumer_write_ready[i] === 1'b1 && prev_cwr[i] !== 1'b1) begin
                log_who.push_back(i);
                log_kind.push_back(1);
                log_data.push_back('0);
            end
        end
        prev_crr = consumer_read_ready;
        prev_cwr = consumer_write_ready;

        if (mem_read_valid === 1'b1 && prev_mrv !== 1'b1) check("mem_rd_valid_while_ready", mem_read_ready, 0);
        if (mem_write_valid === 1'b1 && prev_mwv !== 1'b1) check("mem_wr_valid_while_ready", mem_write_ready, 0);
        prev_mrv = mem_read_valid;
        prev_mwv = mem_write_valid;

        if (mem_read_ready) begin
            if (mem_read_valid !== 1'b1) mem_read_ready = 1'b0;
        end else if (mem_read_valid === 1'b1) begin
            if (rd_cnt == 0 && rand_lat) rd_lat = int'($urandom_range(1, 4));
            rd_cnt++;
            if (rd_cnt >= rd_lat) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem[mem_read_address];
                rd_cnt         = 0;
            end
        end else begin
            rd_cnt = 0;
        end

        if (mem_write_ready) begin
            if (mem_write_valid !== 1'b1) mem_write_ready = 1'b0;
        end else if (mem_write_valid === 1'b1) begin
            if (wr_cnt == 0 && rand_lat) wr_lat = int'($urandom_range(1, 4));
            wr_cnt++;
            if (wr_cnt >= wr_lat) begin
                mem_write_ready         = 1'b1;
                mem[mem_write_address]  = mem_write_data;
                wr_cnt                  = 0;
            end
        end else begin
            wr_cnt = 0;
        end

        for (int i = 0; i < N; i++) begin
            if (consumer_read_valid[i] && consumer_read_ready[i] === 1'b1 && !hold_rd[i]) begin
                consumer_read_valid[i] = 1'b0;
            end else if (!consumer_read_valid[i] && consumer_read_ready[i] !== 1'b1 && rd_rem[i] > 0) begin
                consumer_read_valid[i]           = 1'b1;
                consumer_read_address[i*A +: A] = raddr[i];
                rd_rem[i]--;
            end
            if (consumer_write_valid[i] && consumer_write_ready[i] === 1'b1) begin
                consumer_write_valid[i] = 1'b0;
            end else if (!consumer_write_valid[i] && consumer_write_ready[i] !== 1'b1 && wr_rem[i] > 0) begin
                consumer_write_valid[i]           = 1'b1;
                consumer_write_address[i*A +: A] = waddr[i];
                consumer_write_data[i*D +: D]    = wdata[i];
                wr_rem[i]--;
            end
        end
    endtask

    task automatic clear_log();
        log_who.delete();
        log_kind.delete();
        log_data.delete();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            req_rd[i] = 0;
            req_wr[i] = 0;
        end
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (rd_rem[i] != 0 || wr_rem[i] != 0) ok = 1'b0;
            if (consumer_read_valid != '0 || consumer_write_valid != '0) ok = 1'b0;
            if (consumer_read_ready !== '0 || consumer_write_ready !== '0) ok = 1'b0;
            if (mem_read_valid !== 1'b0 || mem_write_valid !== 1'b0) ok = 1'b0;
            if (mem_read_ready || mem_write_ready) ok = 1'b0;
        end
        check({tag, "_done"}, 32'(ok), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_crd_ready"}, 32'(consumer_read_ready), 0);
        check({tag, "_cwr_ready"}, 32'(consumer_write_ready), 0);
        check({tag, "_crd_data_lo"}, consumer_read_data[31:0], 0);
        check({tag, "_crd_data_hi"}, consumer_read_data[63:32], 0);
        check({tag, "_mrd_valid"}, 32'(mem_read_valid), 0);
        check({tag, "_mrd_addr"}, 32'(mem_read_address), 0);
        check({tag, "_mwr_valid"}, 32'(mem_write_valid), 0);
        check({tag, "_mwr_addr"}, 32'(mem_write_address), 0);
        check({tag, "_mwr_data"}, 32'(mem_write_data), 0);
    endtask

    // Predict the whole batch from the request counts, then let the agents run it.
    task automatic run_batch(input string tag);
        int           left_rd[N], left_wr[N];
        logic [N-1:0] mask;
        int           g;
        exp_who.delete();
        exp_kind.delete();
        exp_data.delete();
        for (int i = 0; i < N; i++) begin
            left_rd[i] = req_rd[i];
            left_wr[i] = req_wr[i];
        end
        forever begin
            mask = '0;
            for (int i = 0; i < N; i++) mask[i] = (left_rd[i] > 0) || (left_wr[i] > 0);
            if (mask == '0) break;
            g = predict_grant(mask);
            exp_who.push_back(g);
            if (left_rd[g] > 0) begin
                exp_kind.push_back(0);
                exp_data.push_back(ref_mem[raddr[g]]);
                left_rd[g]--;
            end else begin
                exp_kind.push_back(1);
                exp_data.push_back('0);
                ref_mem[waddr[g]] = wdata[g];
                left_wr[g]--;
            end
        end
        clear_log();
        for (int i = 0; i < N; i++) begin
            rd_rem[i] = req_rd[i];
            wr_rem[i] = req_wr[i];
        end
        wait_quiet(400, tag);
        check({tag, "_count"}, log_who.size(), exp_who.size());
        for (int k = 0; k < exp_who.size() && k < log_who.size(); k++) begin
            check({tag, "_who"}, log_who[k], exp_who[k]);
            check({tag, "_kind"}, log_kind[k], exp_kind[k]);
            if (exp_kind[k] == 0) check({tag, "_data"}, 32'(log_data[k]), 32'(exp_data[k]));
        end
        for (int i = 0; i < N; i++) begin
            if (req_wr[i] > 0) check({tag, "_memwr"}, 32'(mem[waddr[i]]), 32'(ref_mem[waddr[i]]));
        end
    endtask

    initial begin
        int g;
        int n;

        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
        hold_rd                = '0;
        rd_lat = 3; wr_lat = 2; rd_cnt = 0; wr_cnt = 0; rand_lat = 1'b0;
        model_rr = 0;
        prev_crr = '0; prev_cwr = '0; prev_mrv = 1'b0; prev_mwv = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_rem[i] = 0; wr_rem[i] = 0;
            raddr[i] = '0; waddr[i] = '0; wdata[i] = '0;
        end
        clear_reqs();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = D'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h10]     = 16'h1234;
        ref_mem[8'h10] = 16'h1234;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single read with a fixed 3-cycle memory.
        clear_log();
        raddr[0] = 8'h10;
        g = predict_grant(4'b0001);
        rd_rem[0] = 1;
        tick();
        tick();
        check("single_mem_valid", 32'(mem_read_valid), 1);
        check("single_mem_addr", 32'(mem_read_address), 32'h10);
        n = 1;
        while (log_who.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        check("single_latency", n, 4);
        check("single_seen", log_who.size(), 1);
        if (log_who.size() > 0) begin
            check("single_who", log_who[0], g);
            check("single_data", 32'(log_data[0]), 32'(ref_mem[8'h10]));
        end
        tick();
        check("single_ready_clear", 32'(consumer_read_ready[0]), 0);
        check("single_data_held", 32'(consumer_read_data[15:0]), 32'h1234);
        wait_quiet(50, "single");

        // Bring the pointer back to 0, then three simultaneous readers.
        clear_reqs();
        raddr[3] = 8'h77; req_rd[3] = 1;
        run_batch("rr_align");
        clear_reqs();
        raddr[0] = 8'h01; raddr[1] = 8'h02; raddr[2] = 8'h03;
        req_rd[0] = 1; req_rd[1] = 1; req_rd[2] = 1;
        run_batch("contention");
        if (log_who.size() == 3) begin
            check("contention_first", log_who[0], 0);
            check("contention_second", log_who[1], 1);
            check("contention_third", log_who[2], 2);
        end

        // Two requesters that re-raise immediately must alternate.
        clear_reqs();
        raddr[1] = 8'h55; raddr[3] = 8'h66;
        req_rd[1] = 3; req_rd[3] = 3;
        run_batch("fairness");
        for (int k = 1; k < log_who.size(); k++) check("fairness_alternate", 32'(log_who[k] != log_who[k-1]), 1);

        // Same consumer reads and writes together; read goes first, then read back the write.
        clear_reqs();
        raddr[2] = 8'h20; waddr[2] = 8'h21; wdata[2] = 16'hBEEF;
        req_rd[2] = 1; req_wr[2] = 1;
        run_batch("rw_same");
        clear_reqs();
        raddr[2] = 8'h21; req_rd[2] = 1;
        run_batch("rw_readback");
        if (log_data.size() > 0) check("rw_readback_beef", 32'(log_data[0]), 32'hBEEF);

        // Consumer 0 holds read_valid for 10 cycles after ready.
        clear_log();
        raddr[0] = 8'h30;
        hold_rd[0] = 1'b1;
        g = predict_grant(4'b0001);
        rd_rem[0] = 1;
        n = 0;
        while (log_who.size() == 0 && n < 30) begin
            tick();
            n++;
        end
        check("held_seen", log_who.size(), 1);
        if (log_who.size() > 0) begin
            check("held_who", log_who[0], g);
            check("held_data", 32'(log_data[0]), 32'(ref_mem[8'h30]));
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            check("held_ready", 32'(consumer_read_ready[0]), 1);
            check("held_no_reissue", 32'(mem_read_valid), 0);
        end
        hold_rd[0] = 1'b0;
        tick();
        tick();
        check("held_ready_clear", 32'(consumer_read_ready[0]), 0);
        wait_quiet(50, "held");

        // Reset while the controller waits on a slow memory read.
        clear_log();
        raddr[0] = 8'h10;
        rd_lat = 6;
        rd_rem[0] = 1;
        tick();
        tick();
        check("rst_pre_valid", 32'(mem_read_valid), 1);
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        model_rr = 0;
        clear_log();
        g = predict_grant(4'b0001);
        wait_quiet(60, "post_reset");
        check("post_reset_count", log_who.size(), 1);
        if (log_who.size() > 0) begin
            check("post_reset_who", log_who[0], g);
            check("post_reset_data", 32'(log_data[0]), 32'(ref_mem[8'h10]));
        end

        // Random batches with random latencies and overlapping addresses.
        rand_lat = 1'b1;
        for (int b = 0; b < 8; b++) begin
            clear_reqs();
            for (int i = 0; i < N; i++) begin
                req_rd[i] = int'($urandom_range(0, 2));
                req_wr[i] = int'($urandom_range(0, 1));
                raddr[i]  = 8'h40 + 8'($urandom_range(0, 7));
                waddr[i]  = 8'h40 + 8'($urandom_range(0, 7));
                wdata[i]  = D'($urandom);
            end
            run_batch("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Arbitrates one shared memory port pair (one read channel, one write channel, each with valid/ready handshake) among NUM_CONSUMERS requesters (e.g. per-thread load/store units).
- Round-robin grant, one outstanding transaction at a time.
- Relays address, data and ready between the granted consumer and memory using a four-phase valid/ready handshake on both sides.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 16, data width.
- NUM_CONSUMERS, 4, number of requesters (>=1). The pointer width is clog2 of this, minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  read complete, data valid.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed.
- consumer_write_ready  out  NUM_CONSUMERS  write complete.
- mem_read_valid  out  1; mem_read_address  out  ADDR_BITS; mem_read_ready  in  1; mem_read_data  in  DATA_BITS.
- mem_write_valid  out  1; mem_write_address  out  ADDR_BITS; mem_write_data  out  DATA_BITS; mem_write_ready  in  1.

Behaviour:
- All outputs are registered.
- On reset, every output is 0 (ready vectors, data buses, mem valids, addresses, write data), state = IDLE, rr_ptr = 0, current consumer = 0.
- Reset mid-transaction abandons the transaction. Memory then completes its own handshake because valid is low.

FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.

- IDLE:
  - A consumer is pending if its read_valid or write_valid is 1 and both of its ready outputs are 0.
  - Pick the first pending consumer scanning rr_ptr, rr_ptr+1, ... modulo NUM_CONSUMERS.
  - If that consumer has read_valid, issue the read first. Its write is served on a later grant.
  - Read issue needs mem_read_ready==0; write issue needs mem_write_ready==0. If the required ready is still high, stall in IDLE (no grant, rr_ptr unchanged).
  - On issue: latch current consumer; set rr_ptr <= (granted+1) mod NUM_CONSUMERS.
  - Read issue drives mem_read_valid<=1 and mem_read_address<=that consumer's address, then goes to READ_WAITING.
  - Write issue drives mem_write_valid<=1 plus address and data, then goes to WRITE_WAITING.
  - Memory-side valid rises the cycle after the consumer request is sampled.
- READ_WAITING:
  - Hold valid and address until mem_read_ready==1.
  - Then mem_read_valid<=0, consumer_read_data[cur]<=mem_read_data, consumer_read_ready[cur]<=1, go to READ_RELAYING.
- WRITE_WAITING: on mem_write_ready==1, mem_write_valid<=0, consumer_write_ready[cur]<=1, go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Wait for the consumer to drop its valid.
  - Then clear its ready and return to IDLE.
  - consumer_read_data[cur] keeps its value until the next read for that consumer.
- Other consumers' valids are ignored while busy; they wait, never dropped.
- Each memory transaction costs at least 2 idle cycles of controller overhead (issue cycle + relay/return).
- NUM_CONSUMERS==1 degenerates to a pass-through with no arbitration.

Test Plan:
- Single read: memory model with 3-cycle latency holds 0x1234 at 0x10; consumer 0 raises read_valid addr 0x10.
  -> mem_read_valid rises the next cycle with address 0x10.
  -> consumer_read_ready[0]=1 with data 0x1234.
  -> ready clears one cycle after consumer 0 drops valid.
- Contention: consumers 0,1,2 request reads of 0x01,0x02,0x03 in the same cycle with rr_ptr=0.
  -> served 0,1,2 in that order, each getting its own data.
  -> mem_read_valid is never asserted while mem_read_ready is still high.
- Fairness: consumers 1 and 3 request continuously, re-raising valid right after ready clears.
  -> grants alternate 1,3,1,3; no consumer is granted twice in a row while the other is pending.
- Read+write same consumer: consumer 2 asserts a read of 0x20 and a write of 0xBEEF to 0x21 together.
  -> read completes first, then the write.
  -> a later read of 0x21 returns 0xBEEF.
- Held valid: consumer 0 keeps read_valid high for 10 cycles after ready.
  -> no second memory read is issued; ready stays 1 until valid drops.
- Reset during READ_WAITING: all outputs are 0 the cycle after reset.
  -> after reset releases, a fresh read of 0x10 completes correctly once mem_read_ready has returned low.
